// File: rtl/aes_dec_pkg.sv
// Shared AES decryption types: block width, byte-index helpers, output-buffer states.
package aes_dec_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NB      = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  // Column-major state: byte 4c+r sits at the top of the vector for byte 0.
  function automatic int byte_idx(input int c, input int r);
    return AES_NB * c + r;
  endfunction

  function automatic int byte_msb(input int idx);
    return AES_BLOCK_W - 1 - AES_BYTE_W * idx;
  endfunction

endpackage

// File: rtl/inv_shift_rows_stage_if.sv
// Valid/ready block channel carrying one AES state plus its round tag.
interface inv_shift_rows_stage_if #(parameter int TAG_W = 4) ();

  logic                               valid;
  logic                               ready;
  logic [aes_dec_pkg::AES_BLOCK_W-1:0] data;
  logic [TAG_W-1:0]                   tag;

  modport master (output valid, output data, output tag, input  ready);
  modport slave  (input  valid, input  data, input  tag, output ready);

endinterface

// File: rtl/inv_shift_rows_stage_perm.sv
// Pure InvShiftRows byte permutation: row r of the state rotates right by r.
module inv_shift_rows
  import aes_dec_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] i_data,
  output logic [AES_BLOCK_W-1:0] o_data
);

  for (genvar c = 0; c < AES_NB; c++) begin : g_col
    for (genvar r = 0; r < AES_NB; r++) begin : g_row
      localparam int DST = byte_idx(c, r);
      localparam int SRC = byte_idx((c - r + AES_NB) % AES_NB, r);
      assign o_data[byte_msb(DST) -: AES_BYTE_W] = i_data[byte_msb(SRC) -: AES_BYTE_W];
    end
  end

endmodule

// File: rtl/inv_shift_rows_stage.sv
// InvShiftRows pipeline stage, 1-cycle latency, registered outputs.
// INV_SHIFT_ROWS_SKID_EN: 2-entry skid buffer with registered in_ready; otherwise single register.
module inv_shift_rows_stage
  import aes_dec_pkg::*;
#(
  parameter int TAG_W = 4
)
(
  input  logic clk,
  input  logic reset,
  inv_shift_rows_stage_if.slave  i_in,
  inv_shift_rows_stage_if.master o_out
);

  buf_state_t             r_state;
  buf_state_t             w_next;
  logic [AES_BLOCK_W-1:0] w_perm;
  logic [AES_BLOCK_W-1:0] r_out_data;
  logic [TAG_W-1:0]       r_out_tag;
  logic [AES_BLOCK_W-1:0] w_ld_data;
  logic [TAG_W-1:0]       w_ld_tag;
  logic                   w_ld_out;
  logic                   w_ld_in;
  logic                   w_in_rdy;
  logic                   w_out_vld;
  logic                   w_acc;
  logic                   w_drn;

  inv_shift_rows u_perm (
    .i_data (i_in.data),
    .o_data (w_perm)
  );

  assign w_out_vld   = (r_state != EMPTY);
  assign w_acc       = i_in.valid && w_in_rdy;
  assign w_drn       = w_out_vld && o_out.ready;
  assign i_in.ready  = w_in_rdy;
  assign o_out.valid = w_out_vld;
  assign o_out.data  = r_out_data;
  assign o_out.tag   = r_out_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_next;
  end

`ifdef INV_SHIFT_ROWS_SKID_EN
  logic                   r_rdy;
  logic [AES_BLOCK_W-1:0] r_skid_data;
  logic [TAG_W-1:0]       r_skid_tag;
  logic                   w_ld_skid;
  logic                   w_ld_from_skid;

  always_comb begin
    w_next         = r_state;
    w_ld_in        = 1'b0;
    w_ld_skid      = 1'b0;
    w_ld_from_skid = 1'b0;
    unique case (r_state)
      EMPTY: if (w_acc) begin
               w_next  = ONE;
               w_ld_in = 1'b1;
             end
      ONE: begin
             if (w_acc && w_drn) begin
               w_ld_in = 1'b1;
             end else if (w_acc) begin
               w_next    = TWO;
               w_ld_skid = 1'b1;
             end else if (w_drn) begin
               w_next = EMPTY;
             end
           end
      TWO: if (w_drn) begin
             w_next         = ONE;
             w_ld_from_skid = 1'b1;
           end
      default: w_next = EMPTY;
    endcase
  end

  assign w_ld_out  = w_ld_in || w_ld_from_skid;
  assign w_ld_data = w_ld_from_skid ? r_skid_data : w_perm;
  assign w_ld_tag  = w_ld_from_skid ? r_skid_tag  : i_in.tag;
  assign w_in_rdy  = r_rdy;

  // Ready is computed from the next state so it is registered yet never stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rdy <= 1'b0;
    else       r_rdy <= (w_next != TWO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_data <= '0;
      r_skid_tag  <= '0;
    end else if (w_ld_skid) begin
      r_skid_data <= w_perm;
      r_skid_tag  <= i_in.tag;
    end
  end
`else
  logic r_live;

  always_comb begin
    w_next  = r_state;
    w_ld_in = 1'b0;
    unique case (r_state)
      EMPTY: if (w_acc) begin
               w_next  = ONE;
               w_ld_in = 1'b1;
             end
      ONE: begin
             if (w_acc)      w_ld_in = 1'b1;
             else if (w_drn) w_next  = EMPTY;
           end
      default: w_next = EMPTY;
    endcase
  end

  assign w_ld_out  = w_ld_in;
  assign w_ld_data = w_perm;
  assign w_ld_tag  = i_in.tag;
  // r_live holds ready low through reset; afterwards ready is purely combinational.
  assign w_in_rdy  = r_live && (!w_out_vld || o_out.ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_live <= 1'b0;
    else       r_live <= 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data <= '0;
      r_out_tag  <= '0;
    end else if (w_ld_out) begin
      r_out_data <= w_ld_data;
      r_out_tag  <= w_ld_tag;
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// Directed bench for inv_shift_rows_stage; expectations adapt to INV_SHIFT_ROWS_SKID_EN.
module tb_inv_shift_rows_stage;

`ifdef INV_SHIFT_ROWS_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  inv_shift_rows_stage_if #(.TAG_W(4)) u_in ();
  inv_shift_rows_stage_if #(.TAG_W(4)) u_out ();

  inv_shift_rows_stage #(.TAG_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .i_in  (u_in),
    .o_out (u_out)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ref_isr(input logic [127:0] d);
    logic [7:0]   st [4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[127 - 8*(4*c + r) -: 8];
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8*(4*c + r) -: 8] = st[r][(c + 4 - r) % 4];
    return o;
  endfunction

  function automatic logic [127:0] blk(input int i);
    return 128'h000102030405060708090a0b0c0d0e0f + ({16{8'h10}} * i[7:0]);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] a, b, c, d, e;
    u_in.valid  = 1'b0;
    u_in.data   = '0;
    u_in.tag    = '0;
    u_out.ready = 1'b0;

    // Reset state
    #1 reset = 1'b1;
    #2;
    check("rst_out_valid", u_out.valid, 0);
    check("rst_out_data",  u_out.data,  0);
    check("rst_out_tag",   u_out.tag,   0);
    check("rst_in_ready",  u_in.ready,  0);
    @(negedge clk) reset = 1'b0;
    step();
    check("post_rst_in_ready", u_in.ready, 1);

    // Single block with hand-computed result
    u_in.valid  = 1'b1;
    u_in.data   = 128'h00112233445566778899aabbccddeeff;
    u_in.tag    = 4'd3;
    u_out.ready = 1'b1;
    step();
    check("single_valid", u_out.valid, 1);
    check("single_data",  u_out.data,  128'h00ddaa774411eebb885522ffcc996633);
    check("single_tag",   u_out.tag,   3);
    u_in.valid = 1'b0;
    u_in.data  = '1;
    step();
    check("single_drained", u_out.valid, 0);

    // Back-to-back stream of 16 blocks
    for (int i = 0; i < 16; i++) begin
      u_in.valid = 1'b1;
      u_in.data  = blk(i);
      u_in.tag   = i[3:0];
      step();
      check($sformatf("stream_valid_%0d", i), u_out.valid, 1);
      check($sformatf("stream_data_%0d", i),  u_out.data,  ref_isr(blk(i)));
      check($sformatf("stream_tag_%0d", i),   u_out.tag,   i[3:0]);
    end
    u_in.valid = 1'b0;
    step();
    check("stream_end_valid", u_out.valid, 0);

    // Backpressure: offer A, B, C with downstream stalled
    a = blk(20); b = blk(21); c = blk(22);
    u_out.ready = 1'b0;
    u_in.valid  = 1'b1;
    u_in.data   = a;
    u_in.tag    = 4'hA;
    step();
    check("bp_a_valid", u_out.valid, 1);
    check("bp_a_data",  u_out.data,  ref_isr(a));
    check("bp_rdy_one", u_in.ready,  SKID);
    u_in.data = b;
    u_in.tag  = 4'hB;
    step();
    check("bp_hold1_data", u_out.data, ref_isr(a));
    check("bp_hold1_tag",  u_out.tag,  4'hA);
    check("bp_rdy_full",   u_in.ready, 0);
    if (SKID) begin
      u_in.data = c;
      u_in.tag  = 4'hC;
    end
    step();
    check("bp_hold2_valid", u_out.valid, 1);
    check("bp_hold2_data",  u_out.data,  ref_isr(a));
    check("bp_hold2_rdy",   u_in.ready,  0);

    // Release downstream: skid keeps ready low (registered), single-register raises it at once
    u_out.ready = 1'b1;
    #1;
    check("bp_release_rdy", u_in.ready, !SKID);
    step();
    check("bp_b_valid", u_out.valid, 1);
    check("bp_b_data",  u_out.data,  ref_isr(b));
    check("bp_b_tag",   u_out.tag,   4'hB);
    check("bp_b_rdy",   u_in.ready,  1);
    u_in.data = c;
    u_in.tag  = 4'hC;
    step();
    check("bp_c_valid", u_out.valid, 1);
    check("bp_c_data",  u_out.data,  ref_isr(c));
    check("bp_c_tag",   u_out.tag,   4'hC);
    u_in.valid = 1'b0;
    step();
    check("bp_end_valid", u_out.valid, 0);

    // Fill the buffer, then reset mid-cycle
    d = blk(30); e = blk(31);
    u_out.ready = 1'b0;
    u_in.valid  = 1'b1;
    u_in.data   = d;
    u_in.tag    = 4'h5;
    step();
    u_in.data = e;
    u_in.tag  = 4'h6;
    step();
    check("full_rdy", u_in.ready, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", u_out.valid, 0);
    check("arst_data",  u_out.data,  0);
    check("arst_rdy",   u_in.ready,  0);
    u_in.valid  = 1'b0;
    u_out.ready = 1'b1;
    @(negedge clk) reset = 1'b0;
    step();
    check("arst_post_rdy",   u_in.ready,  1);
    check("arst_post_valid", u_out.valid, 0);
    step();
    check("arst_no_stale", u_out.valid, 0);
    check("arst_tag_clear", u_out.tag,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
